// File: rtl/i281_trace_tx.sv
// i281_trace_tx: snapshots i281 CPU state at each instruction fetch and streams it as byte frames.
//   Ports:
//     clock              - sole clock, rising edge
//     reset              - synchronous, active-low
//     run                - capture enable
//     instruction[4:0]   - decoded opcode
//     state[5:0]         - control-FSM state; entry into IF_STATE triggers a capture
//     reg_a..reg_d[7:0]  - register file contents
//     flags[3:0]         - flag register
//     tx_data[7:0]       - current frame byte
//     tx_valid           - tx_data valid
//     tx_ready           - consumer accepts the byte
//     tx_last            - final (checksum) byte of a frame
//     drop_count[7:0]    - saturating count of snapshots lost to a full FIFO
//   Frame: A5, [seq], instr, state, A, B, C, D, flags, XOR checksum (all bytes after A5).
//   Optional feature: define TRACE_SEQ_EN to insert an 8-bit sequence byte after A5.
module i281_trace_tx #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [5:0] IF_STATE   = 6'd0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run,
  input  logic [4:0] instruction,
  input  logic [5:0] state,
  input  logic [7:0] reg_a,
  input  logic [7:0] reg_b,
  input  logic [7:0] reg_c,
  input  logic [7:0] reg_d,
  input  logic [3:0] flags,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       tx_last,
  output logic [7:0] drop_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef TRACE_SEQ_EN
  localparam int FLEN = 10;
`else
  localparam int FLEN = 9;
`endif
  localparam int NB = FLEN - 2;
  localparam logic [3:0] LAST = 4'(FLEN - 1);

  typedef struct packed {
`ifdef TRACE_SEQ_EN
    logic [7:0] seq;
`endif
    logic [4:0] ins;
    logic [5:0] st;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic [3:0] fl;
  } snap_t;

  typedef enum logic {IDLE, SEND} tx_state_t;

  snap_t         mem_q [FIFO_DEPTH];
  snap_t         wr_snap, head;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [5:0]    prev_q;
  logic [7:0]    drop_q, drop_d;
  tx_state_t     st_q, st_d;
  logic [3:0]    idx_q, idx_d;
  logic          trig, full, accept, pop, push;
  logic [NB*8-1:0] body;
  logic [7:0]    chk, byte_sel;

  // One trigger per instruction: only the edge that enters IF_STATE counts.
  assign trig   = run && state == IF_STATE && prev_q != IF_STATE;
  assign full   = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign accept = tx_valid && tx_ready;
  assign pop    = accept && tx_last;
  // A slot freed by the head frame's final byte in the same cycle is reusable.
  assign push   = trig && (!full || pop);

`ifdef TRACE_SEQ_EN
  logic [7:0] seq_q;
  // Counts every trigger, including dropped ones, so gaps reveal lost frames.
  always_ff @(posedge clock) begin
    if (!reset) seq_q <= '0;
    else if (trig) seq_q <= seq_q + 8'd1;
  end
`endif

  always_comb begin
`ifdef TRACE_SEQ_EN
    wr_snap.seq = seq_q;
`endif
    wr_snap.ins = instruction;
    wr_snap.st  = state;
    wr_snap.a   = reg_a;
    wr_snap.b   = reg_b;
    wr_snap.c   = reg_c;
    wr_snap.d   = reg_d;
    wr_snap.fl  = flags;
  end

  always_comb begin
    wr_d   = push ? wr_q + AW'(1) : wr_q;
    rd_d   = pop ? rd_q + AW'(1) : rd_q;
    cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    drop_d = (trig && !push && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    st_d   = st_q;
    idx_d  = idx_q;
    if (st_q == IDLE) begin
      // Entering SEND on the push edge itself gives tx_valid the cycle after capture.
      st_d  = cnt_d != '0 ? SEND : IDLE;
      idx_d = 4'd0;
    end else if (accept) begin
      idx_d = tx_last ? 4'd0 : idx_q + 4'd1;
      st_d  = (tx_last && cnt_d == '0) ? IDLE : SEND;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      st_q   <= IDLE;
      idx_q  <= 4'd0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      drop_q <= '0;
      prev_q <= IF_STATE;
    end else begin
      st_q   <= st_d;
      idx_q  <= idx_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      drop_q <= drop_d;
      prev_q <= state;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_q] <= wr_snap;
  end

  assign head = mem_q[rd_q];

  always_comb begin
`ifdef TRACE_SEQ_EN
    body = {head.seq, 3'b0, head.ins, 2'b0, head.st, head.a, head.b, head.c, head.d, 4'b0, head.fl};
`else
    body = {3'b0, head.ins, 2'b0, head.st, head.a, head.b, head.c, head.d, 4'b0, head.fl};
`endif
    chk = 8'h00;
    for (int k = 0; k < NB; k++) chk ^= body[k*8 +: 8];
    byte_sel = 8'h00;
    for (int k = 0; k < NB; k++) if (idx_q == 4'(k + 1)) byte_sel = body[(NB-1-k)*8 +: 8];
    tx_data = !tx_valid ? 8'h00 : idx_q == 4'd0 ? 8'hA5 : idx_q == LAST ? chk : byte_sel;
  end

  // Gated by reset so outputs read idle for the whole time reset is held.
  assign tx_valid   = reset && st_q == SEND;
  assign tx_last    = tx_valid && idx_q == LAST;
  assign drop_count = drop_q;
endmodule

// File: tb/tb_i281_trace_tx.sv
// tb_i281_trace_tx: directed, table-driven bench for i281_trace_tx.
module tb_i281_trace_tx;
  logic       clock = 0, reset = 0, run = 0, tx_ready = 0;
  logic [4:0] instruction = 5'd7;
  logic [5:0] state = 6'd1;
  logic [7:0] reg_a = 8'h03, reg_b = 8'h05, reg_c = 8'h07, reg_d = 8'h09;
  logic [3:0] flags = 4'b0010;
  logic [7:0] tx_data, drop_count;
  logic       tx_valid, tx_last;
  int checks = 0, passes = 0;
`ifdef TRACE_SEQ_EN
  localparam int FLEN = 10, RA = 4;
`else
  localparam int FLEN = 9, RA = 3;
`endif

  i281_trace_tx #(.FIFO_DEPTH(4), .IF_STATE(6'd0)) dut (
    .clock(clock), .reset(reset), .run(run), .instruction(instruction), .state(state),
    .reg_a(reg_a), .reg_b(reg_b), .reg_c(reg_c), .reg_d(reg_d), .flags(flags),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .drop_count(drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {logic rdy; logic v; logic [7:0] d; logic l;} vec_t;
  vec_t tab[$];
  logic [7:0] exp_a[$], exp_s[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 0; run = 0; tx_ready = 0; state = 6'd1;
    repeat (3) step();
    check("rst_valid", 32'(tx_valid), 32'd0);
    check("rst_last", 32'(tx_last), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    reset = 1;
    step();
  endtask

  task automatic fire();
    state = 6'd1;
    step();
    state = 6'd0;
    step();
  endtask

  function automatic void add_frame(input logic [7:0] seq, input int stall);
    logic [7:0] b[$];
    b.push_back(8'hA5);
    if (FLEN == 10) b.push_back(seq);
    b = {b, 8'h07, 8'h00, 8'h03, 8'h05, 8'h07, 8'h09, 8'h02, 8'h0D ^ (FLEN == 10 ? seq : 8'h00)};
    for (int i = 0; i < stall; i++) tab.push_back('{1'b0, 1'b1, 8'hA5, 1'b0});
    for (int i = 0; i < b.size(); i++) tab.push_back('{1'b1, 1'b1, b[i], i == b.size() - 1});
    tab.push_back('{1'b1, 1'b0, 8'h00, 1'b0});
  endfunction

  task automatic run_tab(input string tag);
    for (int i = 0; i < tab.size(); i++) begin
      check($sformatf("%s_%0d_valid", tag, i), 32'(tx_valid), 32'(tab[i].v));
      check($sformatf("%s_%0d_data", tag, i), 32'(tx_data), 32'(tab[i].d));
      check($sformatf("%s_%0d_last", tag, i), 32'(tx_last), 32'(tab[i].l));
      tx_ready = tab[i].rdy;
      step();
    end
  endtask

  task automatic collect(input string tag, input int n);
    int frames = 0, pos = 0, gaps = 0, cyc = 0;
    logic [7:0] x = 8'h00;
    logic started = 0;
    while (frames < n && cyc < 300) begin
      if (tx_valid) begin
        started = 1;
        if (pos == 0) check($sformatf("%s_f%0d_sync", tag, frames), 32'(tx_data), 32'hA5);
        if (pos == 1 && FLEN == 10 && frames < exp_s.size())
          check($sformatf("%s_f%0d_seq", tag, frames), 32'(tx_data), 32'(exp_s[frames]));
        if (pos == RA && frames < exp_a.size())
          check($sformatf("%s_f%0d_rega", tag, frames), 32'(tx_data), 32'(exp_a[frames]));
        check($sformatf("%s_f%0d_b%0d_last", tag, frames, pos), 32'(tx_last), 32'(pos == FLEN - 1));
        if (tx_last) begin
          check($sformatf("%s_f%0d_chk", tag, frames), 32'(tx_data), 32'(x));
          x = 8'h00; pos = 0; frames++;
        end else begin
          if (pos > 0) x ^= tx_data;
          pos++;
        end
      end else if (started) gaps++;
      tx_ready = 1;
      step();
      cyc++;
    end
    check({tag, "_frames"}, 32'(frames), 32'(n));
    check({tag, "_gaps"}, 32'(gaps), 32'd0);
    repeat (3) step();
    check({tag, "_idle"}, 32'(tx_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lasts, vcnt;
    // Basic frame, then the same capture held off by 5 stall cycles.
    do_reset();
    run = 1;
    add_frame(8'h00, 0);
    fire();
    run_tab("frame");
    tab.delete();
    add_frame(8'h01, 5);
    tx_ready = 0;
    fire();
    run_tab("stall");

    // Six captures with the consumer stalled: four stored, two dropped.
    do_reset();
    run = 1;
    exp_a = {8'h10, 8'h11, 8'h12, 8'h13};
    exp_s = {8'h00, 8'h01, 8'h02, 8'h03};
    for (int k = 0; k < 6; k++) begin
      reg_a = 8'(8'h10 + k);
      fire();
    end
    check("ovf_drop", 32'(drop_count), 32'd2);
    check("ovf_valid", 32'(tx_valid), 32'd1);
    check("ovf_head", 32'(tx_data), 32'hA5);
    collect("ovf", 4);
    check("ovf_drop_after", 32'(drop_count), 32'd2);

    // Capture on the very edge the full FIFO frees its head slot is kept.
    do_reset();
    run = 1;
    for (int k = 0; k < 4; k++) begin
      reg_a = 8'(8'h10 + k);
      fire();
    end
    state = 6'd1;
    tx_ready = 1;
    repeat (FLEN - 1) step();
    check("edge_last", 32'(tx_last), 32'd1);
    state = 6'd0;
    reg_a = 8'h19;
    step();
    check("edge_drop", 32'(drop_count), 32'd0);
    exp_a = {8'h11, 8'h12, 8'h13, 8'h19};
    exp_s = {8'h01, 8'h02, 8'h03, 8'h04};
    collect("edge", 4);
    reg_a = 8'h03;

    // IF_STATE held for many cycles produces exactly one frame.
    do_reset();
    run = 1;
    tx_ready = 1;
    state = 6'd1;
    step();
    state = 6'd0;
    lasts = 0;
    for (int i = 0; i < 30; i++) begin
      if (tx_last) lasts++;
      step();
    end
    check("hold_frames", 32'(lasts), 32'd1);

    // Reset mid-frame aborts it; next frame restarts at the sync byte.
    do_reset();
    run = 1;
    tx_ready = 1;
    fire();
    repeat (4) step();
    check("abort_b4", 32'(tx_data), FLEN == 10 ? 32'h03 : 32'h05);
    reset = 0;
    step();
    check("abort_valid", 32'(tx_valid), 32'd0);
    check("abort_data", 32'(tx_data), 32'd0);
    check("abort_drop", 32'(drop_count), 32'd0);
    reset = 1;
    step();
    fire();
    check("restart_valid", 32'(tx_valid), 32'd1);
    check("restart_sync", 32'(tx_data), 32'hA5);
    step();
    check("restart_b1", 32'(tx_data), FLEN == 10 ? 32'h00 : 32'h07);
    repeat (12) step();

    // run=0 blocks all captures.
    do_reset();
    run = 0;
    tx_ready = 1;
    vcnt = 0;
    for (int k = 0; k < 5; k++) begin
      fire();
      if (tx_valid) vcnt++;
    end
    check("norun_valid", 32'(vcnt), 32'd0);
    check("norun_drop", 32'(drop_count), 32'd0);

    // Drop counter saturates at 255.
    do_reset();
    run = 1;
    for (int k = 0; k < 262; k++) fire();
    check("sat_drop", 32'(drop_count), 32'd255);
    check("sat_valid", 32'(tx_valid), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
